// File: rtl/rabbit_keystream_xor.sv
// Rabbit keystream consumer: buffers 128-bit keystream blocks and XORs them LSB-slice-first onto a data stream.
// Optional block-usage counter output blk_used enabled by defining RABBIT_XOR_STATS_EN.
module rabbit_keystream_xor #(
    parameter int DATA_W   = 32,
    parameter int KS_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [127:0]      ks_in,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef RABBIT_XOR_STATS_EN
    ,
    output logic [31:0]       blk_used
`endif
);

    localparam int NSL = 128 / DATA_W;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int PW  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int CW  = $clog2(KS_DEPTH + 1);

    logic [127:0]      mem_q [KS_DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doutLast_q, doutLast_d;
    logic              doutValid_q, doutValid_d;

    logic              push;
    logic              accept;
    logic              pop;
    logic              lastSlice;
    logic [127:0]      head;
    logic [DATA_W-1:0] headSlice;

    // Ready terms depend only on registered state (plus flush/dout_ready), never on ks_valid.
    assign ks_ready  = !flush && (count_q < CW'(KS_DEPTH));
    assign din_ready = !flush && (count_q != '0) && (!doutValid_q || dout_ready);

    assign push      = ks_valid && ks_ready;
    assign accept    = din_valid && din_ready;
    assign lastSlice = (idx_q == IW'(NSL - 1));
    assign pop       = accept && (lastSlice || din_last);

    assign head      = mem_q[rdPtr_q];
    assign headSlice = head[int'(idx_q)*DATA_W +: DATA_W];

    assign dout       = dout_q;
    assign dout_last  = doutLast_q;
    assign dout_valid = doutValid_q;

    always_comb begin
        count_d     = count_q;
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        idx_d       = idx_q;
        dout_d      = dout_q;
        doutLast_d  = doutLast_q;
        doutValid_d = doutValid_q;

        if (flush) begin
            count_d     = '0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            idx_d       = '0;
            dout_d      = '0;
            doutLast_d  = 1'b0;
            doutValid_d = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = (wrPtr_q == PW'(KS_DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = (rdPtr_q == PW'(KS_DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end

            // A din_last word discards the rest of the block so the next message starts fresh.
            if (accept) begin
                dout_d      = din ^ headSlice;
                doutLast_d  = din_last;
                doutValid_d = 1'b1;
                idx_d       = pop ? '0 : idx_q + IW'(1);
            end else if (dout_ready) begin
                doutValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= ks_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            idx_q       <= '0;
            dout_q      <= '0;
            doutLast_q  <= 1'b0;
            doutValid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            idx_q       <= idx_d;
            dout_q      <= dout_d;
            doutLast_q  <= doutLast_d;
            doutValid_q <= doutValid_d;
        end
    end

`ifdef RABBIT_XOR_STATS_EN
    logic [31:0] blkUsed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blkUsed_q <= '0;
        end else if (flush) begin
            blkUsed_q <= '0;
        end else if (pop) begin
            blkUsed_q <= blkUsed_q + 32'd1;
        end
    end

    assign blk_used = blkUsed_q;
`endif

endmodule

// File: tb/tb_rabbit_keystream_xor.sv
// Directed bench for rabbit_keystream_xor (DATA_W=32, KS_DEPTH=2) with hand-computed expected words.
module tb_rabbit_keystream_xor;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [127:0] ks_in;
    logic         ks_valid;
    logic         ks_ready;
    logic [31:0]  din;
    logic         din_last;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  dout;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
`ifdef RABBIT_XOR_STATS_EN
    logic [31:0]  blk_used;
`endif

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] BLK_A  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] BLK_B1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK_B2 = 128'h88888888_77777777_66666666_55555555;
    localparam logic [127:0] BLK_B3 = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;
    localparam logic [127:0] BLK_C  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    logic [31:0] expA [4];

    rabbit_keystream_xor #(
        .DATA_W  (32),
        .KS_DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ks_in     (ks_in),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .din       (din),
        .din_last  (din_last),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_last (dout_last),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
`ifdef RABBIT_XOR_STATS_EN
        ,
        .blk_used  (blk_used)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] ks, input logic ksV,
                                 input logic [31:0] d, input logic dLast, input logic dV);
        ks_in     = ks;
        ks_valid  = ksV;
        din       = d;
        din_last  = dLast;
        din_valid = dV;
        #1;
    endtask

    initial begin
        expA[0] = 32'hFCFDFEFF;
        expA[1] = 32'hF8F9FAFB;
        expA[2] = 32'hF4F5F6F7;
        expA[3] = 32'hF0F1F2F3;

        rst_n      = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b1;
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        #12;
        checkOutput("reset_ks_ready", ks_ready, 1);
        checkOutput("reset_din_ready", din_ready, 0);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_dout_last", dout_last, 0);
        #1 rst_n = 1'b1;
        tick();

        // Test 1: single block, four FFFFFFFF words, LSB slice first.
        applyStimulus(BLK_A, 1'b1, '0, 1'b0, 1'b0);
        checkOutput("t1_ks_ready", ks_ready, 1);
        tick();
        applyStimulus('0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        checkOutput("t1_din_ready", din_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t1_dout%0d", i), dout, expA[i]);
            checkOutput($sformatf("t1_valid%0d", i), dout_valid, 1);
        end
        checkOutput("t1_din_ready_empty", din_ready, 0);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t1_valid_drop", dout_valid, 0);

        // Test 2: two blocks, din_last on second word retires block 1 early.
        applyStimulus(BLK_B1, 1'b1, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(BLK_B2, 1'b1, '0, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("t2_full_ks_ready", ks_ready, 0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t2_w0", dout, 32'h11111111);
        checkOutput("t2_w0_last", dout_last, 0);
        applyStimulus('0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("t2_w1", dout, 32'h22222222);
        checkOutput("t2_w1_last", dout_last, 1);
        checkOutput("t2_count1_ks_ready", ks_ready, 1);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t2_w2_blk2_slice0", dout, 32'h55555555);
        checkOutput("t2_w2_last", dout_last, 0);
        applyStimulus('0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("t2_w3", dout, 32'h66666666);
        checkOutput("t2_empty_din_ready", din_ready, 0);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Test 3: downstream stall holds dout bit-exact and blocks input.
        applyStimulus(BLK_C, 1'b1, '0, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t3_w0", dout, 32'hAAAAAAAA);
        dout_ready = 1'b0;
        #1;
        checkOutput("t3_stall_din_ready", din_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("t3_hold_dout%0d", i), dout, 32'hAAAAAAAA);
            checkOutput($sformatf("t3_hold_valid%0d", i), dout_valid, 1);
            checkOutput($sformatf("t3_hold_din_ready%0d", i), din_ready, 0);
        end
        dout_ready = 1'b1;
        tick();
        checkOutput("t3_w1", dout, 32'hBBBBBBBB);
        tick();
        checkOutput("t3_w2", dout, 32'hCCCCCCCC);
        tick();
        checkOutput("t3_w3", dout, 32'hDDDDDDDD);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_valid_drop", dout_valid, 0);

        // Test 4: third block waits for a slot, then lands behind the current head.
        applyStimulus(BLK_B1, 1'b1, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t4_ks_ready_after1", ks_ready, 1);
        applyStimulus(BLK_B2, 1'b1, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t4_ks_ready_after2", ks_ready, 0);
        applyStimulus(BLK_B3, 1'b1, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t4_ks_ready_still_full", ks_ready, 0);
        applyStimulus(BLK_B3, 1'b1, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("t4_blk1", dout, 32'h11111111);
        checkOutput("t4_ks_ready_after_pop", ks_ready, 1);
        tick();
        checkOutput("t4_blk2", dout, 32'h55555555);
        applyStimulus('0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_push_pop_ks_ready", ks_ready, 1);
        tick();
        checkOutput("t4_blk3", dout, 32'h99999999);
        checkOutput("t4_empty_din_ready", din_ready, 0);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Test 5: flush after two of four words.
        applyStimulus(BLK_A, 1'b1, '0, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        tick();
        checkOutput("t5_w0", dout, expA[0]);
        tick();
        checkOutput("t5_w1", dout, expA[1]);
        flush = 1'b1;
        #1;
        checkOutput("t5_flush_din_ready", din_ready, 0);
        checkOutput("t5_flush_ks_ready", ks_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("t5_flush_valid", dout_valid, 0);
        checkOutput("t5_flush_last", dout_last, 0);
        checkOutput("t5_flush_empty", din_ready, 0);
        applyStimulus(BLK_A, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        tick();
        checkOutput("t5_fresh_idx0", dout, expA[0]);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);

        // Test 6: asynchronous reset mid-block, then resume as in test 1.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_dout", dout, 0);
        checkOutput("t6_rst_valid", dout_valid, 0);
        checkOutput("t6_rst_last", dout_last, 0);
        checkOutput("t6_rst_din_ready", din_ready, 0);
        checkOutput("t6_rst_ks_ready", ks_ready, 1);
        #1 rst_n = 1'b1;
        tick();
        applyStimulus(BLK_A, 1'b1, '0, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t6_dout%0d", i), dout, expA[i]);
        end
        checkOutput("t6_empty_din_ready", din_ready, 0);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
